header_stripper: RTL and testbench

HEADER_STRIPPER -- requirements
Module: header_stripper

---
 rtl/header_stripper_if.sv | 22 ++
 rtl/header_stripper.sv | 185 ++++++++++++++++++
 tb/tb_header_stripper.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/header_stripper_if.sv
// avalon_st_if: Avalon-ST style streaming bus (valid/ready handshake with
// packet framing).
//   valid, ready : beat handshake; a beat moves when both are high
//   data         : DATA_WIDTH payload word
//   sop, eop     : first / last beat of a packet
//   empty        : unused bytes in the eop beat
// The master modport drives the beat and the slave modport drives ready.
interface avalon_st_if #(
  parameter int unsigned DATA_WIDTH = 128
);
  localparam int unsigned EMPTY_WIDTH = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1;

  logic                   valid;
  logic                   ready;
  logic [DATA_WIDTH-1:0]  data;
  logic                   sop;
  logic                   eop;
  logic [EMPTY_WIDTH-1:0] empty;

  modport master (output valid, data, sop, eop, empty, input ready);
  modport slave  (input valid, data, sop, eop, empty, output ready);
endinterface

// File: rtl/header_stripper.sv
// header_stripper: removes the first HEADER_SIZE bits (HEADER_SIZE/DATA_WIDTH
// beats) of every packet, publishes them on header_data and passes the
// remaining payload through with zero latency.
//   clk, rst_n      : clock, synchronous active-low reset
//   data_in         : incoming packets (slave side)
//   data_out        : payload with the header removed (master side)
//   header_data     : last complete header, packet word 0 in the MSBs
//   header_valid    : one-cycle pulse when header_data updates
//   runt_err        : one-cycle pulse when a packet ends inside its header
// Optional macro HEADER_STRIPPER_CHECK_EN adds expected_header / hdr_mismatch;
// a packet whose header differs from expected_header is consumed and dropped.
module header_stripper #(
  parameter int unsigned DATA_WIDTH  = 128,
  parameter int unsigned HEADER_SIZE = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  avalon_st_if.slave             data_in,
  avalon_st_if.master            data_out,
  output logic [HEADER_SIZE-1:0] header_data,
  output logic                   header_valid,
  output logic                   runt_err
`ifdef HEADER_STRIPPER_CHECK_EN
  ,
  input  logic [HEADER_SIZE-1:0] expected_header,
  output logic                   hdr_mismatch
`endif
);

  localparam int unsigned HEADER_WORD_COUNT = HEADER_SIZE / DATA_WIDTH;
  localparam int unsigned CNT_W = (HEADER_WORD_COUNT > 1) ? $clog2(HEADER_WORD_COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(HEADER_WORD_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE_ST,
    HEADER_ST,
    DATA_ST
`ifdef HEADER_STRIPPER_CHECK_EN
    ,
    DROP_ST
`endif
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [HEADER_SIZE-1:0] hdr_buf_q, hdr_buf_d;
  logic [HEADER_SIZE-1:0] header_data_d;
  logic                   header_valid_d;
  logic                   runt_err_d;
  logic                   sop_pend_q, sop_pend_d;
  logic                   cap;
  logic [CNT_W-1:0]       slot;
`ifdef HEADER_STRIPPER_CHECK_EN
  logic                   hdr_mismatch_d;
`endif

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE_ST;
      cnt_q        <= '0;
      hdr_buf_q    <= '0;
      header_data  <= '0;
      header_valid <= 1'b0;
      runt_err     <= 1'b0;
      sop_pend_q   <= 1'b1;
`ifdef HEADER_STRIPPER_CHECK_EN
      hdr_mismatch <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hdr_buf_q    <= hdr_buf_d;
      header_data  <= header_data_d;
      header_valid <= header_valid_d;
      runt_err     <= runt_err_d;
      sop_pend_q   <= sop_pend_d;
`ifdef HEADER_STRIPPER_CHECK_EN
      hdr_mismatch <= hdr_mismatch_d;
`endif
    end
  end

  // Next-state logic and the zero-latency stream outputs
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    hdr_buf_d      = hdr_buf_q;
    header_data_d  = header_data;
    header_valid_d = 1'b0;
    runt_err_d     = 1'b0;
    sop_pend_d     = sop_pend_q;
`ifdef HEADER_STRIPPER_CHECK_EN
    hdr_mismatch_d = 1'b0;
`endif
    cap            = 1'b0;
    slot           = '0;

    data_in.ready  = 1'b1;
    data_out.valid = 1'b0;
    data_out.data  = '0;
    data_out.sop   = 1'b0;
    data_out.eop   = 1'b0;
    data_out.empty = '0;

    case (state_q)
      // Only a sop beat starts a header; anything else realigns by discard
      IDLE_ST: begin
        cap  = data_in.valid & data_in.sop;
        slot = '0;
      end

      // Header beats are always accepted, downstream backpressure is irrelevant
      HEADER_ST: begin
        cap  = data_in.valid;
        slot = cnt_q;
      end

      DATA_ST: begin
        data_in.ready  = data_out.ready;
        data_out.valid = data_in.valid;
        data_out.data  = data_in.data;
        data_out.sop   = sop_pend_q;
        data_out.eop   = data_in.eop;
        data_out.empty = data_in.eop ? data_in.empty : '0;
        if (data_in.valid && data_out.ready) begin
          sop_pend_d = 1'b0;
          if (data_in.eop) begin
            state_d    = IDLE_ST;
            cnt_d      = '0;
            sop_pend_d = 1'b1;
          end
        end
      end

`ifdef HEADER_STRIPPER_CHECK_EN
      // Rejected packet: swallow the payload up to eop
      DROP_ST: begin
        if (data_in.valid && data_in.eop) begin
          state_d = IDLE_ST;
        end
      end
`endif

      default: state_d = IDLE_ST;
    endcase

    // Header word capture, shared by IDLE_ST (word 0) and HEADER_ST
    if (cap) begin
      for (int k = 0; k < int'(HEADER_WORD_COUNT); k++) begin
        if (CNT_W'(k) == slot) begin
          hdr_buf_d[HEADER_SIZE-1-k*DATA_WIDTH -: DATA_WIDTH] = data_in.data;
        end
      end
      if (slot == LAST_SLOT) begin
        header_data_d  = hdr_buf_d;
        header_valid_d = 1'b1;
        cnt_d          = '0;
`ifdef HEADER_STRIPPER_CHECK_EN
        hdr_mismatch_d = (hdr_buf_d != expected_header);
`endif
        if (data_in.eop) begin
          state_d = IDLE_ST;
        end
`ifdef HEADER_STRIPPER_CHECK_EN
        else if (hdr_buf_d != expected_header) begin
          state_d = DROP_ST;
        end
`endif
        else begin
          state_d = DATA_ST;
        end
      end else if (data_in.eop) begin
        // Packet ended inside the header: drop the partial header
        runt_err_d = 1'b1;
        state_d    = IDLE_ST;
        cnt_d      = '0;
      end else begin
        state_d = HEADER_ST;
        cnt_d   = slot + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_header_stripper.sv
// tb_header_stripper: directed vector table for header_stripper with the
// default 128-bit bus and 2-word header, plus a drop sequence when
// HEADER_STRIPPER_CHECK_EN is defined.
module tb_header_stripper;

  localparam int unsigned DW = 128;
  localparam int unsigned HS = 256;

  typedef struct {
    logic          rst;
    logic          vld, sop, eop;
    logic [3:0]    emp;
    logic [DW-1:0] dat;
    logic          ordy;
    logic          irdy, ovld, osop, oeop;
    logic [3:0]    oemp;
    logic [DW-1:0] odat;
    logic          hv, re;
    logic [HS-1:0] hdr;
  } vec_t;

  localparam logic [DW-1:0] D0 = 128'hD0, D1 = 128'hD1, D2 = 128'hD2, D3 = 128'hD3, D4 = 128'hD4;
  localparam logic [DW-1:0] E0 = 128'hE0, E1 = 128'hE1, E2 = 128'hE2, E3 = 128'hE3, E4 = 128'hE4;
  localparam logic [DW-1:0] F0 = 128'hF0, F1 = 128'hF1, G0 = 128'h60;
  localparam logic [DW-1:0] P0 = 128'h70, P1 = 128'h71, P2 = 128'h72, P3 = 128'h73, P4 = 128'h74;
  localparam logic [DW-1:0] Q0 = 128'h80, Q1 = 128'h81, Q2 = 128'h82;
  localparam logic [DW-1:0] GA = 128'hAA, GB = 128'hBB, Z = 128'h0;
  localparam logic [HS-1:0] HD = {D0, D1}, HE = {E0, E1}, HF = {F0, F1}, HP = {P0, P1}, HQ = {Q0, Q1};
  localparam logic [HS-1:0] H0 = '0;

  logic clk = 1'b0;
  logic rst_n;
  logic [HS-1:0] header_data;
  logic header_valid;
  logic runt_err;
  int errors = 0;
  int checks = 0;

  avalon_st_if #(.DATA_WIDTH(DW)) in_if ();
  avalon_st_if #(.DATA_WIDTH(DW)) out_if ();

`ifdef HEADER_STRIPPER_CHECK_EN
  logic [HS-1:0] expected_header;
  logic hdr_mismatch;
  logic [DW-1:0] w0 = '0;
  logic bad = 1'b0;
  // Reference header: last accepted sop word followed by the current beat
  always @(posedge clk) if (in_if.valid && in_if.sop && in_if.ready) w0 <= in_if.data;
  assign expected_header = {w0, in_if.data} ^ {{(HS-1){1'b0}}, bad};
`endif

  header_stripper #(.DATA_WIDTH(DW), .HEADER_SIZE(HS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (in_if),
    .data_out     (out_if),
    .header_data  (header_data),
    .header_valid (header_valid),
    .runt_err     (runt_err)
`ifdef HEADER_STRIPPER_CHECK_EN
    ,
    .expected_header (expected_header),
    .hdr_mismatch    (hdr_mismatch)
`endif
  );

  always #5 clk = ~clk;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic vld, logic sop, logic eop, logic [3:0] emp,
                              logic [DW-1:0] dat, logic ordy, logic irdy, logic ovld,
                              logic osop, logic oeop, logic [3:0] oemp, logic [DW-1:0] odat,
                              logic hv, logic re, logic [HS-1:0] hdr);
    vec_t v;
    v.rst = rst; v.vld = vld; v.sop = sop; v.eop = eop; v.emp = emp; v.dat = dat; v.ordy = ordy;
    v.irdy = irdy; v.ovld = ovld; v.osop = osop; v.oeop = oeop; v.oemp = oemp; v.odat = odat;
    v.hv = hv; v.re = re; v.hdr = hdr;
    return v;
  endfunction

  task automatic check(input string name, input logic [HS-1:0] act, input logic [HS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one beat after the falling edge and settle before checking
  task automatic step(input logic rst, input logic vld, input logic sop, input logic eop,
                      input logic [3:0] emp, input logic [DW-1:0] dat, input logic ordy);
    @(negedge clk);
    rst_n = rst; in_if.valid = vld; in_if.sop = sop; in_if.eop = eop;
    in_if.empty = emp; in_if.data = dat; out_if.ready = ordy;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_if.valid = 1'b0; in_if.sop = 1'b0; in_if.eop = 1'b0;
    in_if.empty = '0; in_if.data = '0; out_if.ready = 1'b1;

    //        rst vld sop eop emp dat ordy | irdy ovld osop oeop oemp odat hv re hdr
    // reset state
    vecs.push_back(mk(0,0,0,0,0,Z ,1, 1,0,0,0,0,Z ,0,0,H0));
    // 5-beat packet, ready held high
    vecs.push_back(mk(1,0,0,0,0,Z ,1, 1,0,0,0,0,Z ,0,0,H0));
    vecs.push_back(mk(1,1,1,0,0,D0,1, 1,0,0,0,0,Z ,0,0,H0));
    vecs.push_back(mk(1,1,0,0,0,D1,1, 1,0,0,0,0,Z ,0,0,H0));
    vecs.push_back(mk(1,1,0,0,0,D2,1, 1,1,1,0,0,D2,1,0,HD));
    vecs.push_back(mk(1,1,0,0,0,D3,1, 1,1,0,0,0,D3,0,0,HD));
    vecs.push_back(mk(1,1,0,1,3,D4,1, 1,1,0,1,3,D4,0,0,HD));
    vecs.push_back(mk(1,0,0,0,0,Z ,1, 1,0,0,0,0,Z ,0,0,HD));
    // backpressure: header ignores ready, payload ready alternates
    vecs.push_back(mk(1,1,1,0,0,E0,0, 1,0,0,0,0,Z ,0,0,HD));
    vecs.push_back(mk(1,1,0,0,0,E1,0, 1,0,0,0,0,Z ,0,0,HD));
    vecs.push_back(mk(1,1,0,0,0,E2,0, 0,1,1,0,0,E2,1,0,HE));
    vecs.push_back(mk(1,1,0,0,0,E2,1, 1,1,1,0,0,E2,0,0,HE));
    vecs.push_back(mk(1,0,0,0,0,Z ,1, 1,0,0,0,0,Z ,0,0,HE));
    vecs.push_back(mk(1,1,0,0,0,E3,0, 0,1,0,0,0,E3,0,0,HE));
    vecs.push_back(mk(1,1,0,0,0,E3,1, 1,1,0,0,0,E3,0,0,HE));
    vecs.push_back(mk(1,1,0,1,5,E4,0, 0,1,0,1,5,E4,0,0,HE));
    vecs.push_back(mk(1,1,0,1,5,E4,1, 1,1,0,1,5,E4,0,0,HE));
    vecs.push_back(mk(1,0,0,0,0,Z ,0, 1,0,0,0,0,Z ,0,0,HE));
    // header-only packet, then a runt
    vecs.push_back(mk(1,1,1,0,0,F0,1, 1,0,0,0,0,Z ,0,0,HE));
    vecs.push_back(mk(1,1,0,1,2,F1,1, 1,0,0,0,0,Z ,0,0,HE));
    vecs.push_back(mk(1,0,0,0,0,Z ,1, 1,0,0,0,0,Z ,1,0,HF));
    vecs.push_back(mk(1,0,0,0,0,Z ,1, 1,0,0,0,0,Z ,0,0,HF));
    vecs.push_back(mk(1,1,1,1,0,G0,1, 1,0,0,0,0,Z ,0,0,HF));
    vecs.push_back(mk(1,0,0,0,0,Z ,1, 1,0,0,0,0,Z ,0,1,HF));
    vecs.push_back(mk(1,0,0,0,0,Z ,1, 1,0,0,0,0,Z ,0,0,HF));
    // garbage realignment, sop inside payload ignored
    vecs.push_back(mk(1,1,0,0,0,GA,1, 1,0,0,0,0,Z ,0,0,HF));
    vecs.push_back(mk(1,1,0,1,0,GB,1, 1,0,0,0,0,Z ,0,0,HF));
    vecs.push_back(mk(1,1,1,0,0,P0,1, 1,0,0,0,0,Z ,0,0,HF));
    vecs.push_back(mk(1,1,0,0,0,P1,1, 1,0,0,0,0,Z ,0,0,HF));
    vecs.push_back(mk(1,1,0,0,0,P2,1, 1,1,1,0,0,P2,1,0,HP));
    vecs.push_back(mk(1,1,1,0,0,P3,1, 1,1,0,0,0,P3,0,0,HP));
    vecs.push_back(mk(1,1,0,1,7,P4,1, 1,1,0,1,7,P4,0,0,HP));
    vecs.push_back(mk(1,0,0,0,0,Z ,1, 1,0,0,0,0,Z ,0,0,HP));
    // reset during D3, D4 discarded, next packet clean
    vecs.push_back(mk(1,1,1,0,0,D0,1, 1,0,0,0,0,Z ,0,0,HP));
    vecs.push_back(mk(1,1,0,0,0,D1,1, 1,0,0,0,0,Z ,0,0,HP));
    vecs.push_back(mk(1,1,0,0,0,D2,1, 1,1,1,0,0,D2,1,0,HD));
    vecs.push_back(mk(0,1,0,0,0,D3,1, 1,1,0,0,0,D3,0,0,HD));
    vecs.push_back(mk(1,1,0,1,3,D4,1, 1,0,0,0,0,Z ,0,0,H0));
    vecs.push_back(mk(1,1,1,0,0,Q0,1, 1,0,0,0,0,Z ,0,0,H0));
    vecs.push_back(mk(1,1,0,0,0,Q1,1, 1,0,0,0,0,Z ,0,0,H0));
    vecs.push_back(mk(1,1,0,1,1,Q2,1, 1,1,1,1,1,Q2,1,0,HQ));
    vecs.push_back(mk(1,0,0,0,0,Z ,1, 1,0,0,0,0,Z ,0,0,HQ));

    @(posedge clk);
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].vld, vecs[i].sop, vecs[i].eop, vecs[i].emp, vecs[i].dat, vecs[i].ordy);
      check($sformatf("v%0d in_ready", i), HS'(in_if.ready), HS'(vecs[i].irdy));
      check($sformatf("v%0d out_valid", i), HS'(out_if.valid), HS'(vecs[i].ovld));
      if (vecs[i].ovld) begin
        check($sformatf("v%0d out_sop", i), HS'(out_if.sop), HS'(vecs[i].osop));
        check($sformatf("v%0d out_eop", i), HS'(out_if.eop), HS'(vecs[i].oeop));
        check($sformatf("v%0d out_empty", i), HS'(out_if.empty), HS'(vecs[i].oemp));
        check($sformatf("v%0d out_data", i), HS'(out_if.data), HS'(vecs[i].odat));
      end
      check($sformatf("v%0d header_valid", i), HS'(header_valid), HS'(vecs[i].hv));
      check($sformatf("v%0d runt_err", i), HS'(runt_err), HS'(vecs[i].re));
      check($sformatf("v%0d header_data", i), header_data, vecs[i].hdr);
`ifdef HEADER_STRIPPER_CHECK_EN
      check($sformatf("v%0d hdr_mismatch", i), HS'(hdr_mismatch), HS'(0));
`endif
    end

`ifdef HEADER_STRIPPER_CHECK_EN
    // Mismatching header: payload consumed, nothing forwarded
    bad = 1'b1;
    step(1,1,1,0,0,D0,1);
    step(1,1,0,0,0,D1,1);
    step(1,1,0,0,0,D2,0);
    check("drop mismatch", HS'(hdr_mismatch), HS'(1));
    check("drop header_valid", HS'(header_valid), HS'(1));
    check("drop header_data", header_data, HD);
    check("drop D2 valid", HS'(out_if.valid), HS'(0));
    check("drop D2 ready", HS'(in_if.ready), HS'(1));
    step(1,1,0,0,0,D3,1);
    check("drop mismatch clear", HS'(hdr_mismatch), HS'(0));
    check("drop D3 valid", HS'(out_if.valid), HS'(0));
    step(1,1,0,1,3,D4,1);
    check("drop D4 valid", HS'(out_if.valid), HS'(0));
    bad = 1'b0;
    step(1,1,1,0,0,E0,1);
    step(1,1,0,0,0,E1,1);
    step(1,1,0,1,0,E2,1);
    check("post-drop valid", HS'(out_if.valid), HS'(1));
    check("post-drop sop", HS'(out_if.sop), HS'(1));
    check("post-drop data", HS'(out_if.data), HS'(E2));
    check("post-drop mismatch", HS'(hdr_mismatch), HS'(0));
    step(1,0,0,0,0,Z,1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
